// File: rtl/hdd_server_pkg.sv
// Shared definitions for the HDD sector server: FSM states, sector geometry and timeout default.
package hdd_server_pkg;

    localparam int SECTOR_BYTES    = 512;
    localparam int IDX_W           = 9;
    localparam int DEFAULT_TIMEOUT = 4095;

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(SECTOR_BYTES - 1);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_RD_REQ,
        ST_RD_WB,
        ST_WR_FETCH,
        ST_WR_REQ,
        ST_FINISH
    } state_t;

endpackage

// File: rtl/hdd_sector_server_edge.sv
// Rising-edge detector for the controller's read/write request levels.
module hdd_sector_server_edge (
    input  logic       clk_sys,
    input  logic       reset,
    input  logic [1:0] level,
    output logic [1:0] rise
);

    logic [1:0] level_q;

    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) level_q <= '0;
        else       level_q <= level;
    end

    assign rise = level & ~level_q;

endmodule

// File: rtl/hdd_sector_server.sv
// Moves one 512-byte sector between the controller's sector RAM and the disk-image store.
// Optional img_ack watchdog enabled by defining HDD_SERVER_TIMEOUT_EN.
module hdd_sector_server
    import hdd_server_pkg::*;
#(
    parameter int IMG_AW  = 25,
    parameter int TIMEOUT = DEFAULT_TIMEOUT
) (
    input  logic              clk_sys,
    input  logic              reset,
    input  logic [15:0]       sector,
    input  logic              hdd_read,
    input  logic              hdd_write,
    input  logic              hdd_mounted,
    input  logic              hdd_protect,
    output logic [8:0]        ram_addr,
    output logic [7:0]        ram_di,
    input  logic [7:0]        ram_do,
    output logic              ram_we,
    output logic [IMG_AW-1:0] img_addr,
    output logic              img_rd,
    output logic              img_wr,
    output logic [7:0]        img_dout,
    input  logic [7:0]        img_din,
    input  logic              img_ack,
    output logic              busy,
    output logic              done,
    output logic              error,
    output state_t            dbg_state
);

    // Handshake: img_rd/img_wr are raised by this block and held until the
    // store returns a single-cycle img_ack; the request drops on the next edge.
    state_t           state;
    logic [15:0]      lba;
    logic [IDX_W-1:0] idx;
    logic             fetch_wait;
    logic [1:0]       req_rise;
    logic             rd_rise;
    logic             wr_rise;

`ifdef HDD_SERVER_TIMEOUT_EN
    localparam logic [11:0] TMO_LAST = 12'(TIMEOUT - 1);
    logic [11:0] tmo_cnt;
`endif

    hdd_sector_server_edge u_edge (
        .clk_sys (clk_sys),
        .reset   (reset),
        .level   ({hdd_write, hdd_read}),
        .rise    (req_rise)
    );

    assign rd_rise   = req_rise[0];
    assign wr_rise   = req_rise[1];
    assign dbg_state = state;

    function automatic logic [IMG_AW-1:0] img_addr_of(input logic [15:0] s, input logic [IDX_W-1:0] i);
        logic [24:0] full;
        full = {s, i};
        return IMG_AW'(full);
    endfunction

    always_ff @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            state      <= ST_IDLE;
            lba        <= '0;
            idx        <= '0;
            fetch_wait <= 1'b0;
            ram_addr   <= '0;
            ram_di     <= '0;
            ram_we     <= 1'b0;
            img_addr   <= '0;
            img_rd     <= 1'b0;
            img_wr     <= 1'b0;
            img_dout   <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
            error      <= 1'b0;
`ifdef HDD_SERVER_TIMEOUT_EN
            tmo_cnt    <= '0;
`endif
        end else begin
            done   <= 1'b0;
            ram_we <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (rd_rise || wr_rise) begin
                        lba   <= sector;
                        idx   <= '0;
                        error <= 1'b0;
                        busy  <= 1'b1;
                        // Read wins a tie, so protect only matters for a lone write edge.
                        if (!hdd_mounted || (!rd_rise && hdd_protect)) begin
                            error <= 1'b1;
                            done  <= 1'b1;
                            state <= ST_FINISH;
                        end else if (rd_rise) begin
                            img_rd   <= 1'b1;
                            img_addr <= img_addr_of(sector, '0);
                            state    <= ST_RD_REQ;
                        end else begin
                            ram_addr   <= '0;
                            fetch_wait <= 1'b0;
                            state      <= ST_WR_FETCH;
                        end
                    end
                end
                ST_RD_REQ: begin
                    if (img_ack) begin
                        ram_di   <= img_din;
                        img_rd   <= 1'b0;
                        ram_addr <= idx;
                        ram_we   <= 1'b1;
                        state    <= ST_RD_WB;
`ifdef HDD_SERVER_TIMEOUT_EN
                        tmo_cnt  <= '0;
                    end else if (tmo_cnt == TMO_LAST) begin
                        img_rd  <= 1'b0;
                        error   <= 1'b1;
                        done    <= 1'b1;
                        tmo_cnt <= '0;
                        state   <= ST_FINISH;
                    end else begin
                        tmo_cnt <= tmo_cnt + 12'd1;
`endif
                    end
                end
                ST_RD_WB: begin
                    if (idx == LAST_IDX) begin
                        done  <= 1'b1;
                        state <= ST_FINISH;
                    end else begin
                        idx      <= idx + 1'b1;
                        img_rd   <= 1'b1;
                        img_addr <= img_addr_of(lba, idx + 1'b1);
                        state    <= ST_RD_REQ;
                    end
                end
                ST_WR_FETCH: begin
                    // First cycle presents ram_addr; ram_do is valid on the second.
                    if (!fetch_wait) begin
                        fetch_wait <= 1'b1;
                    end else begin
                        fetch_wait <= 1'b0;
                        img_dout   <= ram_do;
                        img_wr     <= 1'b1;
                        img_addr   <= img_addr_of(lba, idx);
                        state      <= ST_WR_REQ;
                    end
                end
                ST_WR_REQ: begin
                    if (img_ack) begin
                        img_wr <= 1'b0;
`ifdef HDD_SERVER_TIMEOUT_EN
                        tmo_cnt <= '0;
`endif
                        if (idx == LAST_IDX) begin
                            done  <= 1'b1;
                            state <= ST_FINISH;
                        end else begin
                            idx      <= idx + 1'b1;
                            ram_addr <= idx + 1'b1;
                            state    <= ST_WR_FETCH;
                        end
`ifdef HDD_SERVER_TIMEOUT_EN
                    end else if (tmo_cnt == TMO_LAST) begin
                        img_wr  <= 1'b0;
                        error   <= 1'b1;
                        done    <= 1'b1;
                        tmo_cnt <= '0;
                        state   <= ST_FINISH;
                    end else begin
                        tmo_cnt <= tmo_cnt + 12'd1;
`endif
                    end
                end
                ST_FINISH: begin
                    busy  <= 1'b0;
                    state <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_hdd_sector_server.sv
// Directed bench for hdd_sector_server: sector RAM and image store models plus ordered scoreboards.
module tb_hdd_sector_server;
    import hdd_server_pkg::*;

    localparam int IMG_AW = 25;
    localparam int W      = 17;

    logic              clk_sys = 1'b0;
    logic              reset;
    logic [15:0]       sector;
    logic              hdd_read, hdd_write, hdd_mounted, hdd_protect;
    logic [8:0]        ram_addr;
    logic [7:0]        ram_di;
    logic [7:0]        ram_do;
    logic              ram_we;
    logic [IMG_AW-1:0] img_addr;
    logic              img_rd, img_wr;
    logic [7:0]        img_dout;
    logic [7:0]        img_din;
    logic              img_ack;
    logic              busy, done, error;
    state_t            dbg_state;

    int n_cmp = 0;
    int n_err = 0;
    int we_cnt = 0, rd_ack_cnt = 0, wr_ack_cnt = 0, done_cnt = 0;

    logic [W-1:0]  exp_q[$];
    logic [32:0]   img_q[$];
    logic [7:0]    sram[512];
    logic          ack_en;
    int            ack_dly;

    hdd_sector_server #(.IMG_AW(IMG_AW)) dut (
        .clk_sys     (clk_sys),
        .reset       (reset),
        .sector      (sector),
        .hdd_read    (hdd_read),
        .hdd_write   (hdd_write),
        .hdd_mounted (hdd_mounted),
        .hdd_protect (hdd_protect),
        .ram_addr    (ram_addr),
        .ram_di      (ram_di),
        .ram_do      (ram_do),
        .ram_we      (ram_we),
        .img_addr    (img_addr),
        .img_rd      (img_rd),
        .img_wr      (img_wr),
        .img_dout    (img_dout),
        .img_din     (img_din),
        .img_ack     (img_ack),
        .busy        (busy),
        .done        (done),
        .error       (error),
        .dbg_state   (dbg_state)
    );

    // clock / reset
    always #5 clk_sys = ~clk_sys;

    // sector RAM with one-cycle read latency
    always @(posedge clk_sys) ram_do <= sram[ram_addr];

    // image store: ack two cycles after a request, data = addr[7:0] ^ 8'h5A
    always @(posedge clk_sys or posedge reset) begin
        if (reset) begin
            img_ack <= 1'b0;
            img_din <= 8'h00;
            ack_dly <= 0;
        end else if ((img_rd || img_wr) && !img_ack && ack_en) begin
            if (ack_dly == 1) begin
                img_ack <= 1'b1;
                img_din <= img_addr[7:0] ^ 8'h5A;
                ack_dly <= 0;
            end else begin
                ack_dly <= ack_dly + 1;
            end
        end else begin
            img_ack <= 1'b0;
        end
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // scoreboard: RAM writes and image handshakes must match the queued order
    always @(negedge clk_sys) begin
        if (!reset) begin
            if (ram_we) begin
                we_cnt++;
                if (exp_q.size() == 0) check("ram_we_unexpected", ram_we, 1'b0);
                else check("ram_write", {ram_addr, ram_di}, exp_q.pop_front());
            end
            if (img_ack && img_rd) begin
                rd_ack_cnt++;
                if (img_q.size() == 0) check("img_rd_unexpected", img_rd, 1'b0);
                else check("img_rd_addr", {img_addr, 8'h00}, img_q.pop_front());
            end
            if (img_ack && img_wr) begin
                wr_ack_cnt++;
                if (img_q.size() == 0) check("img_wr_unexpected", img_wr, 1'b0);
                else check("img_wr_addr_data", {img_addr, img_dout}, img_q.pop_front());
            end
            if (img_rd && img_wr) check("rd_wr_exclusive", {img_rd, img_wr}, 2'b00);
            if (done) done_cnt++;
        end
    end

    // driver tasks
    task automatic push_read(input logic [15:0] s);
        logic [8:0] a;
        for (int i = 0; i < 512; i++) begin
            a = 9'(i);
            exp_q.push_back({a, a[7:0] ^ 8'h5A});
            img_q.push_back({s, a, 8'h00});
        end
    endtask

    task automatic push_write(input logic [15:0] s);
        logic [8:0] a;
        for (int i = 0; i < 512; i++) begin
            a = 9'(i);
            img_q.push_back({s, a, a[7:0]});
        end
    endtask

    task automatic wait_done(input int budget, input string tag, output int n);
        int base;
        base = done_cnt;
        n = 0;
        while (done_cnt == base && n < budget) begin
            @(negedge clk_sys);
            #1;
            n++;
        end
        check(tag, done_cnt != base, 1'b1);
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, "_ctrl"}, {busy, done, error, ram_we, img_rd, img_wr}, 6'b0);
        check({tag, "_addr"}, {ram_addr, img_addr}, '0);
        check({tag, "_data"}, {ram_di, img_dout}, '0);
        check({tag, "_state"}, dbg_state, ST_IDLE);
    endtask

    initial begin : stimulus
        int n, b_we, b_rd, b_wr, b_done, hi;
        reset = 1'b1; hdd_read = 1'b0; hdd_write = 1'b0; sector = '0;
        hdd_mounted = 1'b0; hdd_protect = 1'b0; ack_en = 1'b1;
        for (int i = 0; i < 512; i++) sram[i] = i[7:0];
        repeat (3) @(negedge clk_sys);
        #1;
        check_idle_outputs("reset");
        reset = 1'b0;
        @(negedge clk_sys); #1;

        // read sector 3
        hdd_mounted = 1'b1;
        sector = 16'h0003;
        push_read(16'h0003);
        b_we = we_cnt; b_rd = rd_ack_cnt; b_done = done_cnt;
        hdd_read = 1'b1;
        wait_done(6000, "rd3_done", n);
        check("rd3_we_count", we_cnt - b_we, 512);
        check("rd3_img_count", rd_ack_cnt - b_rd, 512);
        check("rd3_error", error, 1'b0);
        check("rd3_queue_left", exp_q.size() + img_q.size(), 0);
        @(negedge clk_sys); #1;
        check("rd3_done_once", done_cnt - b_done, 1);
        check("rd3_busy_after", busy, 1'b0);
        hdd_read = 1'b0;
        @(negedge clk_sys); #1;

        // write sector FFFF from preloaded RAM
        sector = 16'hFFFF;
        push_write(16'hFFFF);
        b_we = we_cnt; b_wr = wr_ack_cnt; b_done = done_cnt;
        hdd_write = 1'b1;
        wait_done(8000, "wrF_done", n);
        check("wrF_img_count", wr_ack_cnt - b_wr, 512);
        check("wrF_no_ram_we", we_cnt - b_we, 0);
        check("wrF_error", error, 1'b0);
        check("wrF_queue_left", img_q.size(), 0);
        @(negedge clk_sys); #1;
        check("wrF_done_once", done_cnt - b_done, 1);
        hdd_write = 1'b0;
        @(negedge clk_sys); #1;

        // protected write: immediate error
        hdd_protect = 1'b1;
        b_we = we_cnt; b_wr = wr_ack_cnt;
        hdd_write = 1'b1;
        wait_done(3, "prot_done_fast", n);
        check("prot_error", error, 1'b1);
        check("prot_no_access", {wr_ack_cnt - b_wr, we_cnt - b_we}, 64'd0);
        check("prot_img_wr", img_wr, 1'b0);
        hdd_write = 1'b0;
        hdd_protect = 1'b0;
        @(negedge clk_sys); #1;
        check("prot_busy_after", busy, 1'b0);

        // unmounted read: immediate error
        hdd_mounted = 1'b0;
        b_we = we_cnt; b_rd = rd_ack_cnt;
        hdd_read = 1'b1;
        wait_done(3, "unmnt_done_fast", n);
        check("unmnt_error", error, 1'b1);
        check("unmnt_no_access", {rd_ack_cnt - b_rd, we_cnt - b_we}, 64'd0);
        check("unmnt_img_rd", img_rd, 1'b0);
        hdd_read = 1'b0;
        hdd_mounted = 1'b1;
        @(negedge clk_sys); #1;

        // held read level plus a write edge while busy
        sector = 16'h0001;
        push_read(16'h0001);
        b_we = we_cnt; b_wr = wr_ack_cnt; b_done = done_cnt;
        hdd_read = 1'b1;
        repeat (20) @(negedge clk_sys);
        #1;
        check("hold_busy", busy, 1'b1);
        hdd_write = 1'b1;
        @(negedge clk_sys); #1;
        hdd_write = 1'b0;
        wait_done(6000, "hold_done", n);
        check("hold_error_cleared", error, 1'b0);
        repeat (2000) @(negedge clk_sys);
        #1;
        check("hold_done_once", done_cnt - b_done, 1);
        check("hold_write_dropped", wr_ack_cnt - b_wr, 0);
        check("hold_we_count", we_cnt - b_we, 512);
        check("hold_busy_idle", busy, 1'b0);
        hdd_read = 1'b0;
        @(negedge clk_sys); #1;

        // reset at idx 100 of a read, then a full read
        sector = 16'h0005;
        push_read(16'h0005);
        b_we = we_cnt; b_done = done_cnt;
        hdd_read = 1'b1;
        n = 0;
        while (we_cnt - b_we < 100 && n < 2000) begin
            @(negedge clk_sys); #1;
            n++;
        end
        check("mid_reached_100", we_cnt - b_we, 100);
        reset = 1'b1;
        #1;
        check_idle_outputs("mid_reset");
        exp_q.delete();
        img_q.delete();
        hdd_read = 1'b0;
        @(negedge clk_sys); #1;
        reset = 1'b0;
        check("mid_no_done", done_cnt - b_done, 0);
        @(negedge clk_sys); #1;
        push_read(16'h0005);
        b_we = we_cnt;
        hdd_read = 1'b1;
        wait_done(6000, "rerun_done", n);
        check("rerun_we_count", we_cnt - b_we, 512);
        check("rerun_queue_left", exp_q.size() + img_q.size(), 0);
        hdd_read = 1'b0;
        @(negedge clk_sys); #1;

        // image store never acknowledges
        ack_en = 1'b0;
        sector = 16'h0007;
        b_rd = rd_ack_cnt;
        hdd_read = 1'b1;
`ifdef HDD_SERVER_TIMEOUT_EN
        hi = 0;
        n = 0;
        b_done = done_cnt;
        while (done_cnt == b_done && n < 6000) begin
            @(negedge clk_sys); #1;
            if (img_rd) hi++;
            n++;
        end
        check("tmo_done", done_cnt - b_done, 1);
        check("tmo_rd_cycles", hi, 4095);
        check("tmo_img_rd_dropped", img_rd, 1'b0);
        check("tmo_error", error, 1'b1);
`else
        hi = 0;
        for (int c = 0; c < 10000; c++) begin
            @(negedge clk_sys); #1;
            if (busy) hi++;
        end
        check("hang_busy_cycles", hi, 10000);
        check("hang_img_rd_held", img_rd, 1'b1);
`endif
        check("hang_no_ack", rd_ack_cnt - b_rd, 0);
        hdd_read = 1'b0;
        reset = 1'b1;
        #1;
        check("hang_reset_busy", busy, 1'b0);
        @(negedge clk_sys);
        reset = 1'b0;

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/hdd_sector_server.md
Name: hdd_sector_server

Overview:
Host-side responder for the HDD sector-buffer interface. It services the `hdd_read`/`hdd_write` requests raised by the HDD controller. Each request moves exactly 512 bytes between the controller's sector RAM (ram_* port) and a byte-wide disk-image store (img_* port). It sits beside the core at top level and drives the same HDD_RAM_ADDR/DI/WE lines the core consumes as inputs.

Parameters:
- IMG_AW, 25, byte address width of the image store (2^16 sectors x 512 B).
- TIMEOUT, 4095, cycles to wait for img_ack before abort (only with HDD_SERVER_TIMEOUT_EN).

Ports:
- clk_sys  in  1  system clock; all state on rising edge
- reset  in  1  asynchronous, active-high reset
- sector  in  16  LBA from controller, latched at request start
- hdd_read  in  1  controller request: image -> sector RAM
- hdd_write  in  1  controller request: sector RAM -> image
- hdd_mounted  in  1  image present
- hdd_protect  in  1  image write-protected
- ram_addr  out  9  sector RAM byte address
- ram_di  out  8  byte written into sector RAM
- ram_do  in  8  byte read from sector RAM; valid 1 cycle after ram_addr
- ram_we  out  1  sector RAM write strobe, 1 cycle per byte
- img_addr  out  IMG_AW  image byte address = {sector, idx[8:0]} zero-extended/truncated to IMG_AW
- img_rd  out  1  image read request, held until img_ack
- img_wr  out  1  image write request, held until img_ack
- img_dout  out  8  write data to image
- img_din  in  8  read data; valid in the cycle img_ack=1
- img_ack  in  1  one-cycle completion from image store
- busy  out  1  transfer in progress
- done  out  1  one-cycle pulse at transfer end
- error  out  1  sticky since last request start: unmounted, protect or timeout

Behaviour:
- Reset values: all outputs 0; FSM in IDLE; idx=0.
- Requests are rising-edge detected against a registered copy of hdd_read/hdd_write. Levels held high after done do not retrigger.
- Edges arriving while busy are ignored. A simultaneous read and write edge resolves as read.
- FSM states: IDLE, RD_REQ, RD_WB, WR_FETCH, WR_REQ, FINISH.
- IDLE:
  - On an edge, latch sector, clear idx and error.
  - If !hdd_mounted, or a write with hdd_protect=1: set error and go to FINISH with no image or RAM access.
  - Otherwise a read goes to RD_REQ and a write goes to WR_FETCH.
- RD_REQ:
  - img_rd=1 with img_addr={lba,idx}.
  - On img_ack, capture img_din to ram_di, drop img_rd, go to RD_WB.
- RD_WB:
  - ram_addr=idx, ram_we=1 for exactly one cycle.
  - If idx==511, go to FINISH; else idx+1 and go to RD_REQ.
- WR_FETCH:
  - ram_addr=idx; wait one cycle, then latch ram_do into img_dout and go to WR_REQ.
- WR_REQ:
  - img_wr=1 until img_ack.
  - Then: if idx==511, go to FINISH; else idx+1 and go to WR_FETCH.
- FINISH: done=1 for one cycle; return to IDLE.
- busy=1 in every state except IDLE.
- idx is 9-bit and never wraps inside a transfer; 512 bytes are transferred exactly.
- img_ack outside RD_REQ/WR_REQ is ignored.
- img_rd and img_wr are never both high.
- Reset mid-transfer: everything returns to reset values immediately. A partial sector is left as written; done does not pulse.

Optional Feature:
- Macro: HDD_SERVER_TIMEOUT_EN.
- Enabled: a 12-bit counter runs in RD_REQ/WR_REQ and clears on img_ack. On reaching TIMEOUT, drop the request, set error, go to FINISH.
- Disabled: no counter; the FSM waits indefinitely for img_ack.

Decomposition:
- Shared package `hdd_server_pkg`:
  - FSM state enum
  - SECTOR_BYTES=512
  - IDX_W=9
  - default TIMEOUT
- No sub-module required; a small `edge_detect` helper is acceptable for the two request inputs.

Test Plan:
- Read, mounted, sector=16'h0003, image store returns byte = addr[7:0]^8'h5A with ack 2 cycles after request:
  - 512 ram_we pulses, addresses 0..511, ram_di=(i^8'h5A)
  - img_addr 0x600..0x7FF
  - one done pulse, error=0
- Write, sector=16'hFFFF, sector RAM preloaded with i[7:0]:
  - 512 img_wr handshakes, img_addr {16'hFFFF,i}, img_dout=i
  - ram_we never asserted; done once
- Write with hdd_protect=1: no img_wr, no ram_we; error=1, done pulse within 3 cycles of the edge. Repeat with hdd_mounted=0 on a read: same result.
- hdd_read held high 2000 cycles after done; hdd_write edge pulsed during a busy read: only one transfer occurs and the write is dropped.
- Reset asserted at idx=100 of a read: all outputs 0 in the same cycle; a new read afterwards completes all 512 bytes from idx 0.
- With HDD_SERVER_TIMEOUT_EN and img_ack never asserted: img_rd drops after 4095 cycles, error=1, done pulses. Without the macro: busy stays 1 for 10000 cycles.
